// File: rtl/wb_pkg.sv
// Wishbone definitions shared by the on-chip Wishbone slaves.
// Holds the cycle-type codes and the common slave state encoding.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        BURST,
        ERR
    } wb_slv_state_t;

endpackage

// File: rtl/wb_ram_slave_if.sv
// Wishbone B3 bus bundle between the interconnect (master) and the RAM front end (slave).
interface wb_ram_slave_if #(
    parameter int ADR_W = 8
) ();

    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic               wb_we_i;
    logic [ADR_W+1:0]   wb_adr_i;
    logic [3:0]         wb_sel_i;
    logic [31:0]        wb_dat_i;
    logic [2:0]         wb_cti_i;
    logic [31:0]        wb_dat_o;
    logic               wb_ack_o;
    logic               wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone slave front end for the 2^ADR_W x 32 byte-enable synchronous RAM.
// Hides the one-cycle RAM read latency and prefetches so incrementing bursts ack every cycle.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int ADR_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    wb_ram_slave_if.slave      wb,
    output logic               ram_we_o,
    output logic [ADR_W-1:0]   ram_adr_o,
    output logic [3:0]         ram_be_o,
    output logic [31:0]        ram_dat_o,
    input  logic [31:0]        ram_dat_i
);

    wb_slv_state_t      state_q, state_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [ADR_W-1:0]   adr_word;
    logic [ADR_W-1:0]   adr_inc;
    logic               req;
    logic               aligned;
    logic               ack;
    logic               err;
    logic               we;
    logic [ADR_W-1:0]   adr_mux;

    assign req      = wb.wb_cyc_i & wb.wb_stb_i;
    assign aligned  = (wb.wb_adr_i[1:0] == 2'b00);
    assign adr_word = wb.wb_adr_i[ADR_W+1:2];
    assign adr_inc  = adr_q + ADR_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        ack     = 1'b0;
        err     = 1'b0;
        we      = 1'b0;
        adr_mux = adr_word;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        state_d = ERR;
                    end else begin
                        we      = wb.wb_we_i;
                        adr_d   = adr_word;
                        state_d = (wb.wb_cti_i == CTI_INCR) ? BURST : ACK;
                    end
                end
            end
            ACK: begin
                adr_mux = adr_q;
                ack     = req;
                state_d = IDLE;
            end
            BURST: begin
                // Writes land on the current beat; reads look one word ahead for the next beat.
                adr_mux = wb.wb_we_i ? adr_q : adr_inc;
                if (req) begin
                    ack   = 1'b1;
                    we    = wb.wb_we_i;
                    adr_d = adr_inc;
                    if (wb.wb_cti_i != CTI_INCR) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                err     = req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The RAM-side outputs decode live bus inputs, so hold them quiet while reset is asserted.
        if (!rst_n_i) begin
            we      = 1'b0;
            adr_mux = '0;
        end
    end

    assign ram_we_o    = we;
    assign ram_adr_o   = adr_mux;
    assign ram_be_o    = wb.wb_sel_i;
    assign ram_dat_o   = wb.wb_dat_i;

    assign wb.wb_ack_o = ack;
    assign wb.wb_err_o = err;
    assign wb.wb_dat_o = (ack && !wb.wb_we_i) ? ram_dat_i : '0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave with a behavioural 256x32 byte-enable RAM alongside.
module tb_wb_ram_slave;
    import wb_pkg::*;

    localparam int ADR_W = 8;

    logic               clk_i;
    logic               rst_n_i;
    logic               ram_we;
    logic [ADR_W-1:0]   ram_adr;
    logic [3:0]         ram_be;
    logic [31:0]        ram_wdat;
    logic [31:0]        ram_rdat;

    logic               pl_en;
    logic [ADR_W-1:0]   pl_adr;
    logic [31:0]        pl_dat;
    logic [31:0]        mem [2**ADR_W] = '{default: 32'h0};

    int n_vec = 0;
    int n_err = 0;

    wb_ram_slave_if #(.ADR_W(ADR_W)) wb ();

    wb_ram_slave #(.ADR_W(ADR_W)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wb        (wb),
        .ram_we_o  (ram_we),
        .ram_adr_o (ram_adr),
        .ram_be_o  (ram_be),
        .ram_dat_o (ram_wdat),
        .ram_dat_i (ram_rdat)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // RAM model: registered read returning old data on read-during-write, plus a preload port.
    always @(posedge clk_i) begin
        if (pl_en) begin
            mem[pl_adr] <= pl_dat;
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
        end
        ram_rdat <= mem[ram_adr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic cyc, input logic we, input logic [ADR_W+1:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat, input logic [2:0] cti);
        wb.wb_cyc_i = cyc;
        wb.wb_stb_i = cyc;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_sel_i = sel;
        wb.wb_dat_i = dat;
        wb.wb_cti_i = cti;
    endtask

    task automatic idle_bus();
        drive(1'b0, 1'b0, '0, 4'h0, 32'h0, CTI_CLASSIC);
    endtask

    task automatic preload(input logic [ADR_W-1:0] adr, input logic [31:0] dat);
        pl_en  = 1'b1;
        pl_adr = adr;
        pl_dat = dat;
        tick();
        pl_en  = 1'b0;
    endtask

    // One classic access: no ack in the request cycle, ack (and read data) the cycle after.
    task automatic classic(input string tag, input logic we, input logic [ADR_W+1:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat, input logic [31:0] exp_rd);
        drive(1'b1, we, adr, sel, dat, CTI_CLASSIC);
        sample();
        check({tag, "_ack_early"}, 32'(wb.wb_ack_o), 32'h0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'(we));
        check({tag, "_ram_be"}, 32'(ram_be), 32'(sel));
        tick();
        sample();
        check({tag, "_ack"}, 32'(wb.wb_ack_o), 32'h1);
        check({tag, "_no_err"}, 32'(wb.wb_err_o), 32'h0);
        if (!we) check({tag, "_rdata"}, wb.wb_dat_o, exp_rd);
        else     check({tag, "_no_rewrite"}, 32'(ram_we), 32'h0);
        tick();
        idle_bus();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pl_en   = 1'b0;
        pl_adr  = '0;
        pl_dat  = '0;
        rst_n_i = 1'b0;
        // Request a write during reset: nothing may leak onto the outputs.
        drive(1'b1, 1'b1, 10'h014, 4'hF, 32'h1234_5678, CTI_CLASSIC);
        repeat (3) tick();
        sample();
        check("rst_ack", 32'(wb.wb_ack_o), 32'h0);
        check("rst_err", 32'(wb.wb_err_o), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_adr", 32'(ram_adr), 32'h0);
        check("rst_dat", wb.wb_dat_o, 32'h0);
        tick();
        idle_bus();
        rst_n_i = 1'b1;
        tick();

        // Classic write, read back, byte-lane write, zero-select write.
        classic("wr_full", 1'b1, 10'h010, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        sample();
        check("mem4_full", mem[4], 32'hDEAD_BEEF);
        tick();
        classic("rd_full", 1'b0, 10'h010, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        classic("wr_byte", 1'b1, 10'h010, 4'b0010, 32'h0000_AA00, 32'h0);
        classic("rd_byte", 1'b0, 10'h010, 4'b1111, 32'h0, 32'hDEAD_AAEF);
        classic("wr_sel0", 1'b1, 10'h010, 4'b0000, 32'hFFFF_FFFF, 32'h0);
        classic("rd_sel0", 1'b0, 10'h010, 4'b1111, 32'h0, 32'hDEAD_AAEF);

        // Incrementing read burst across the top of the address space.
        preload(8'd254, 32'hA5A5_00FE);
        preload(8'd255, 32'hA5A5_00FF);
        preload(8'd0,   32'h5A5A_0000);
        preload(8'd1,   32'h5A5A_0001);
        drive(1'b1, 1'b0, 10'h3F8, 4'hF, 32'h0, CTI_INCR);
        sample();
        check("brd_ack_early", 32'(wb.wb_ack_o), 32'h0);
        tick();
        sample();
        check("brd0_ack", 32'(wb.wb_ack_o), 32'h1);
        check("brd0_dat", wb.wb_dat_o, 32'hA5A5_00FE);
        tick();
        drive(1'b1, 1'b0, 10'h3FC, 4'hF, 32'h0, CTI_INCR);
        sample();
        check("brd1_ack", 32'(wb.wb_ack_o), 32'h1);
        check("brd1_dat", wb.wb_dat_o, 32'hA5A5_00FF);
        check("brd1_prefetch_wrap", 32'(ram_adr), 32'h0);
        tick();
        drive(1'b1, 1'b0, 10'h000, 4'hF, 32'h0, CTI_INCR);
        sample();
        check("brd2_ack", 32'(wb.wb_ack_o), 32'h1);
        check("brd2_dat", wb.wb_dat_o, 32'h5A5A_0000);
        tick();
        drive(1'b1, 1'b0, 10'h004, 4'hF, 32'h0, CTI_EOB);
        sample();
        check("brd3_ack", 32'(wb.wb_ack_o), 32'h1);
        check("brd3_dat", wb.wb_dat_o, 32'h5A5A_0001);
        tick();
        idle_bus();
        sample();
        check("brd_end_idle", 32'(dut.state_q), 32'(IDLE));
        check("brd_end_ack", 32'(wb.wb_ack_o), 32'h0);
        tick();

        // Misaligned read and write: error one cycle after the strobe, never a RAM write.
        drive(1'b1, 1'b0, 10'h013, 4'hF, 32'h0, CTI_CLASSIC);
        sample();
        check("mis_rd_err_early", 32'(wb.wb_err_o), 32'h0);
        tick();
        sample();
        check("mis_rd_err", 32'(wb.wb_err_o), 32'h1);
        check("mis_rd_no_ack", 32'(wb.wb_ack_o), 32'h0);
        tick();
        drive(1'b1, 1'b1, 10'h012, 4'hF, 32'h0, CTI_CLASSIC);
        sample();
        check("mis_wr_no_we", 32'(ram_we), 32'h0);
        tick();
        sample();
        check("mis_wr_err", 32'(wb.wb_err_o), 32'h1);
        check("mis_wr_no_we_err", 32'(ram_we), 32'h0);
        tick();
        idle_bus();
        sample();
        check("mis_mem4", mem[4], 32'hDEAD_AAEF);
        tick();

        // Write burst aborted by dropping cyc after two acked beats.
        preload(8'd10, 32'hCAFE_000A);
        preload(8'd11, 32'hCAFE_000B);
        drive(1'b1, 1'b1, 10'h020, 4'hF, 32'hB0B0_0000, CTI_INCR);
        tick();
        sample();
        check("bwr0_ack", 32'(wb.wb_ack_o), 32'h1);
        check("bwr0_adr", 32'(ram_adr), 32'd8);
        tick();
        drive(1'b1, 1'b1, 10'h024, 4'hF, 32'hB0B0_0001, CTI_INCR);
        sample();
        check("bwr1_ack", 32'(wb.wb_ack_o), 32'h1);
        check("bwr1_adr", 32'(ram_adr), 32'd9);
        tick();
        drive(1'b0, 1'b1, 10'h028, 4'hF, 32'hB0B0_0002, CTI_INCR);
        wb.wb_stb_i = 1'b1;
        sample();
        check("bwr_abort_ack", 32'(wb.wb_ack_o), 32'h0);
        check("bwr_abort_we", 32'(ram_we), 32'h0);
        tick();
        idle_bus();
        sample();
        check("bwr_mem8", mem[8], 32'hB0B0_0000);
        check("bwr_mem9", mem[9], 32'hB0B0_0001);
        check("bwr_mem10", mem[10], 32'hCAFE_000A);
        check("bwr_mem11", mem[11], 32'hCAFE_000B);
        check("bwr_idle", 32'(dut.state_q), 32'(IDLE));
        tick();

        // Asynchronous reset in the middle of a write burst.
        drive(1'b1, 1'b1, 10'h030, 4'hF, 32'h1234_5678, CTI_INCR);
        tick();
        sample();
        check("rstb_ack_pre", 32'(wb.wb_ack_o), 32'h1);
        check("rstb_we_pre", 32'(ram_we), 32'h1);
        rst_n_i = 1'b0;
        #1;
        check("rstb_ack", 32'(wb.wb_ack_o), 32'h0);
        check("rstb_err", 32'(wb.wb_err_o), 32'h0);
        check("rstb_we", 32'(ram_we), 32'h0);
        tick();
        idle_bus();
        rst_n_i = 1'b1;
        tick();
        classic("rd_after_rst", 1'b0, 10'h010, 4'hF, 32'h0, 32'hDEAD_AAEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
